pie_tx: RTL and testbench
=========================

# pie_tx

Programmable PIE (pulse-interval encoding) reader-to-tag transmitter. It is the parametrised successor of the fixed-timing PIE encoder and sits between the control FSM and the TX pin. Per frame it emits a delimiter, a data-0 symbol and RTCAL, plus TRCAL when a full preamble is requested. It then serialises command bits taken over a one-bit ready/valid handshake. All timings are runtime registers latched at frame start; the block adds underrun detection, config checking and a done pulse.

## Interface
- CNT_W, 16: width of all timing counts (clk cycles)
- DEF_PW, 200: reset value of the cfg_pw shadow register
- DEF_DATA0, 500: reset value of the data0 shadow register
- DEF_DATA1, 875: reset value of the data1 shadow register
- DEF_DELIM, 312: reset value of the delim shadow register
- DEF_TRCAL, 4000: reset value of the trcal shadow register

- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_pw, cfg_data0, cfg_data1, cfg_delim, cfg_trcal  in  CNT_W each  timing config, sampled only on an accepted start
- start  in  1  frame request pulse
- start_preamble  in  1  sampled with start; 1 selects preamble (with TRCAL), 0 selects frame-sync
- busy  out  1  frame in progress
- in_dat  in  1  command bit
- in_vld  in  1  bit valid
- in_last  in  1  marks the final bit, sampled with in_dat
- in_rdy  out  1  one-cycle bit request
- out_pie  out  1  PIE output; 1 is CW (carrier on)
- done  out  1  one-cycle pulse when a frame completes
- err  out  1  one-cycle pulse on underrun or rejected config

## Operation
- States: IDLE, DELIM, SYNC0, RTCAL, TRCAL, BIT_REQ, BIT_SYM.
- Symbol of period P: out_pie high for P−pw cycles, then low for pw cycles.
- IDLE: out_pie=1 and busy=0. A start while busy is ignored.
- Config check on start: pw≠0, pw<data0<data1, and (preamble only) trcal>data0+data1.
  - Fail: err pulses, state stays IDLE, config is not latched.
  - Pass: config is latched, busy=1, state goes to DELIM.
- DELIM: out_pie low for delim cycles → SYNC0 (symbol, P=data0) → RTCAL (symbol, P=data0+data1).
- After RTCAL: preamble mode → TRCAL (symbol, P=trcal) → BIT_REQ; frame-sync mode → BIT_REQ.
- BIT_REQ: in_rdy=1 for exactly one cycle.
  - in_vld=1: capture in_dat and in_last, go to BIT_SYM with P=data0 for bit 0 or data1 for bit 1.
  - in_vld=0 (underrun): err pulses, out_pie=1, return to IDLE; done does not pulse.
- BIT_SYM end: if the captured in_last=0, go to BIT_REQ; else go to IDLE with done=1 for that cycle.
- Width rule: RTCAL is computed in CNT_W+1 bits. Counters load P−1 and count down, so no wrap is possible.
- Reset mid-frame: out_pie goes to 1 asynchronously and all state clears.

## Timing
- Reset values: out_pie=1, busy=0, in_rdy=0, done=0, err=0; config shadow registers take the DEF_* values.
- start accepted in cycle t: out_pie=0 and busy=1 from cycle t+1.
- BIT_REQ costs one cycle, during which out_pie=1. That cycle counts as the first high cycle of the following symbol, so symbol periods stay exact.
- The cycle done pulses: busy=0 and out_pie=1. A start in the same cycle is accepted, so back-to-back frames are legal.
- err and done are never asserted together.

## Structure
- Shared package pie_pkg holds:
  - the state enum;
  - the PIE_MODE_SYNC and PIE_MODE_PREAMBLE constants;
  - the CNT_W default;
  - a function that checks config validity.
- Sub-module pie_symbol_timer:
  - inputs: period, pw, load;
  - outputs: phase (high/low) and a last-cycle flag;
  - it is reused for DELIM by setting pw equal to the delim count.

## Test plan
- Default config, frame-sync mode, bits 1,0,1,0 with in_vld tied high:
  - out_pie low 312 cycles, then high 300/low 200 (SYNC0), then high 1175/low 200 (RTCAL);
  - bits: 675/200, 300/200, 675/200, 300/200;
  - done pulses once, on the cycle after the last low cycle.
- Preamble mode, default config: TRCAL segment is high 3800/low 200, between RTCAL and the first in_rdy.
- in_vld held low at the second BIT_REQ: err pulses, done stays 0, out_pie=1, busy falls the same cycle.
- cfg_pw=600 with cfg_data0=500: start produces err, busy stays 0, out_pie stays 1.
- rst_n asserted mid-RTCAL while out_pie=0: out_pie goes to 1 before the next edge; after release the block is IDLE.
- start asserted on the done cycle with new config cfg_delim=100: the next frame's delimiter is 100 cycles low, and out_pie falls 1 cycle after start.

Source files
------------

// File: rtl/pie_pkg.sv
// Shared PIE transmitter definitions: FSM states, preamble mode encoding and config validation.
package pie_pkg;

  localparam int PIE_CNT_W = 16;

  localparam logic PIE_MODE_SYNC     = 1'b0;
  localparam logic PIE_MODE_PREAMBLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELIM,
    ST_SYNC0,
    ST_RTCAL,
    ST_TRCAL,
    ST_BIT_REQ,
    ST_BIT_SYM
  } pie_state_t;

  // Operands are zero-extended to 32 bits so the sum cannot overflow.
  function automatic logic pie_cfg_ok(input logic [31:0] pw,
                                      input logic [31:0] data0,
                                      input logic [31:0] data1,
                                      input logic [31:0] trcal,
                                      input logic        mode);
    logic [32:0] rtcal;
    rtcal = {1'b0, data0} + {1'b0, data1};
    return (pw != '0) && (pw < data0) && (data0 < data1) &&
           ((mode != PIE_MODE_PREAMBLE) || ({1'b0, trcal} > rtcal));
  endfunction

endpackage

// File: rtl/pie_symbol_timer.sv
// Down-counter for one PIE symbol: high while count >= pw, low for the final pw cycles.
// A zero period is clamped to a single cycle so the counter never wraps.
import pie_pkg::*;

module pie_symbol_timer #(
  parameter int CNT_W = PIE_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W:0]   period,
  input  logic [CNT_W-1:0] pw,
  input  logic             load,
  output logic             phase,
  output logic             last
);

  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

  logic [CNT_W:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (period == '0) ? '0 : period - ONE;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign phase = (cnt >= {1'b0, pw});
  assign last  = (cnt == '0);

endmodule

// File: rtl/pie_tx.sv
// PIE reader-to-tag transmitter: delimiter, data-0, RTCAL, optional TRCAL, then one symbol per command bit.
// out_pie falls the cycle after an accepted start; each bit is pulled with a one-cycle in_rdy that doubles as its first high cycle.
import pie_pkg::*;

module pie_tx #(
  parameter int CNT_W     = PIE_CNT_W,
  parameter int DEF_PW    = 200,
  parameter int DEF_DATA0 = 500,
  parameter int DEF_DATA1 = 875,
  parameter int DEF_DELIM = 312,
  parameter int DEF_TRCAL = 4000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_pw,
  input  logic [CNT_W-1:0] cfg_data0,
  input  logic [CNT_W-1:0] cfg_data1,
  input  logic [CNT_W-1:0] cfg_delim,
  input  logic [CNT_W-1:0] cfg_trcal,
  input  logic             start,
  input  logic             start_preamble,
  output logic             busy,
  input  logic             in_dat,
  input  logic             in_vld,
  input  logic             in_last,
  output logic             in_rdy,
  output logic             out_pie,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

  pie_state_t       state, state_nxt;
  logic [CNT_W-1:0] pw_q, data0_q, data1_q, delim_q, trcal_q;
  logic             mode_q;
  logic             last_q;
  logic             done_q, err_q;

  logic             cfg_latch, bit_capture, done_nxt, err_nxt;
  logic             tmr_load, tmr_phase, tmr_last;
  logic [CNT_W:0]   tmr_period;
  logic [CNT_W-1:0] tmr_pw;
  logic [CNT_W:0]   rtcal_period;
  logic             cfg_valid;

  assign rtcal_period = {1'b0, data0_q} + {1'b0, data1_q};
  assign cfg_valid    = pie_cfg_ok(32'(cfg_pw), 32'(cfg_data0), 32'(cfg_data1),
                                   32'(cfg_trcal), start_preamble);

  // The delimiter is an all-low symbol: pw equal to its period.
  assign tmr_pw = (state == ST_DELIM) ? delim_q : pw_q;

  pie_symbol_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .period (tmr_period),
    .pw     (tmr_pw),
    .load   (tmr_load),
    .phase  (tmr_phase),
    .last   (tmr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tmr_load    = 1'b0;
    tmr_period  = '0;
    cfg_latch   = 1'b0;
    bit_capture = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (cfg_valid) begin
            cfg_latch  = 1'b1;
            tmr_load   = 1'b1;
            tmr_period = {1'b0, cfg_delim};
            state_nxt  = ST_DELIM;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_DELIM: begin
        if (tmr_last) begin
          tmr_load   = 1'b1;
          tmr_period = {1'b0, data0_q};
          state_nxt  = ST_SYNC0;
        end
      end
      ST_SYNC0: begin
        if (tmr_last) begin
          tmr_load   = 1'b1;
          tmr_period = rtcal_period;
          state_nxt  = ST_RTCAL;
        end
      end
      ST_RTCAL: begin
        if (tmr_last) begin
          if (mode_q == PIE_MODE_PREAMBLE) begin
            tmr_load   = 1'b1;
            tmr_period = {1'b0, trcal_q};
            state_nxt  = ST_TRCAL;
          end else begin
            state_nxt = ST_BIT_REQ;
          end
        end
      end
      ST_TRCAL: begin
        if (tmr_last) begin
          state_nxt = ST_BIT_REQ;
        end
      end
      ST_BIT_REQ: begin
        if (in_vld) begin
          // This request cycle was already the symbol's first high cycle.
          bit_capture = 1'b1;
          tmr_load    = 1'b1;
          tmr_period  = {1'b0, (in_dat ? data1_q : data0_q)} - ONE;
          state_nxt   = ST_BIT_SYM;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_BIT_SYM: begin
        if (tmr_last) begin
          if (last_q) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_BIT_REQ;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_q    <= CNT_W'(DEF_PW);
      data0_q <= CNT_W'(DEF_DATA0);
      data1_q <= CNT_W'(DEF_DATA1);
      delim_q <= CNT_W'(DEF_DELIM);
      trcal_q <= CNT_W'(DEF_TRCAL);
      mode_q  <= PIE_MODE_SYNC;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (cfg_latch) begin
        pw_q    <= cfg_pw;
        data0_q <= cfg_data0;
        data1_q <= cfg_data1;
        delim_q <= cfg_delim;
        trcal_q <= cfg_trcal;
        mode_q  <= start_preamble;
      end
      if (bit_capture) begin
        last_q <= in_last;
      end
      done_q <= done_nxt;
      err_q  <= err_nxt;
    end
  end

  assign busy    = (state != ST_IDLE);
  assign in_rdy  = (state == ST_BIT_REQ);
  assign out_pie = (state == ST_IDLE || state == ST_BIT_REQ) ? 1'b1 : tmr_phase;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_pie_tx.sv
// Randomized bench for pie_tx: expected waveforms are built from symbol periods and compared cycle by cycle.
module tb_pie_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_pw, cfg_data0, cfg_data1, cfg_delim, cfg_trcal;
  logic        start, start_preamble;
  logic        busy, in_dat, in_vld, in_last, in_rdy, out_pie, done, err;

  int n_checks = 0;
  int n_pass   = 0;

  int   c_pw, c_d0, c_d1, c_delim, c_trcal;
  logic c_pre;
  logic bits[$];
  logic exp_wave[$];
  logic exp_rdy[$];
  int   exp_rdy_pos[$];

  always #5 clk = ~clk;

  pie_tx dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_pw(cfg_pw), .cfg_data0(cfg_data0), .cfg_data1(cfg_data1),
    .cfg_delim(cfg_delim), .cfg_trcal(cfg_trcal),
    .start(start), .start_preamble(start_preamble), .busy(busy),
    .in_dat(in_dat), .in_vld(in_vld), .in_last(in_last), .in_rdy(in_rdy),
    .out_pie(out_pie), .done(done), .err(err)
  );

  task automatic add_sym(input int p, input logic first_is_req);
    for (int k = 0; k < p; k++) begin
      exp_wave.push_back(k < p - c_pw);
      exp_rdy.push_back(first_is_req && k == 0);
      if (first_is_req && k == 0) exp_rdy_pos.push_back(exp_wave.size() - 1);
    end
  endtask

  task automatic build_model();
    exp_wave.delete(); exp_rdy.delete(); exp_rdy_pos.delete();
    repeat (c_delim) begin exp_wave.push_back(1'b0); exp_rdy.push_back(1'b0); end
    add_sym(c_d0, 1'b0);
    add_sym(c_d0 + c_d1, 1'b0);
    if (c_pre) add_sym(c_trcal, 1'b0);
    foreach (bits[b]) add_sym(bits[b] ? c_d1 : c_d0, 1'b1);
  endtask

  task automatic set_default_cfg();
    c_pw = 200; c_d0 = 500; c_d1 = 875; c_delim = 312; c_trcal = 4000;
  endtask

  task automatic rand_cfg();
    c_pw    = $urandom_range(1, 20);
    c_d0    = c_pw + $urandom_range(1, 30);
    c_d1    = c_d0 + $urandom_range(1, 30);
    c_trcal = c_d0 + c_d1 + $urandom_range(1, 40);
    c_delim = $urandom_range(1, 30);
  endtask

  task automatic rand_bits(input int n);
    bits.delete();
    repeat (n) bits.push_back(1'($urandom_range(0, 1)));
  endtask

  // Caller is at a negedge; start is sampled on the following posedge.
  task automatic launch();
    cfg_pw = 16'(c_pw); cfg_data0 = 16'(c_d0); cfg_data1 = 16'(c_d1);
    cfg_delim = 16'(c_delim); cfg_trcal = 16'(c_trcal);
    start_preamble = c_pre;
    start = 1'b1;
  endtask

  // Index 0 is the first cycle after start; uidx >= 0 withholds in_vld at that bit request.
  task automatic check_frame(input string name, input int uidx);
    int l_end, idx, bad_w, bad_r, bad_b, bad_q;
    idx = 0; bad_w = 0; bad_r = 0; bad_b = 0; bad_q = 0;
    build_model();
    l_end = (uidx >= 0) ? exp_rdy_pos[uidx] + 1 : exp_wave.size();
    for (int i = 0; i <= l_end; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i < l_end) begin
        if (out_pie !== exp_wave[i]) begin
          if (bad_w == 0) $display("FAIL %s wave cycle %0d: out_pie=%b expected %b", name, i, out_pie, exp_wave[i]);
          bad_w++;
        end
        if (in_rdy !== exp_rdy[i]) begin
          if (bad_r == 0) $display("FAIL %s in_rdy cycle %0d: got %b expected %b", name, i, in_rdy, exp_rdy[i]);
          bad_r++;
        end
        if (busy !== 1'b1) begin
          if (bad_b == 0) $display("FAIL %s busy cycle %0d: got %b expected 1", name, i, busy);
          bad_b++;
        end
        if ({done, err} !== 2'b00) begin
          if (bad_q == 0) $display("FAIL %s done/err cycle %0d: got %b%b expected 00", name, i, done, err);
          bad_q++;
        end
        in_dat  = (idx < bits.size()) ? bits[idx] : 1'b0;
        in_last = (idx == bits.size() - 1);
        in_vld  = (idx != uidx);
        if (in_rdy) idx++;
      end else begin
        in_vld = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s end busy: got %b expected 0", name, busy); else n_pass++;
        n_checks++;
        if (out_pie !== 1'b1) $display("FAIL %s end out_pie: got %b expected 1", name, out_pie); else n_pass++;
        n_checks++;
        if (done !== (uidx < 0)) $display("FAIL %s end done: got %b expected %b", name, done, uidx < 0); else n_pass++;
        n_checks++;
        if (err !== (uidx >= 0)) $display("FAIL %s end err: got %b expected %b", name, err, uidx >= 0); else n_pass++;
      end
    end
    n_checks += 4;
    if (bad_w == 0) n_pass++;
    if (bad_r == 0) n_pass++;
    if (bad_b == 0) n_pass++;
    if (bad_q == 0) n_pass++;
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if ({out_pie, busy, in_rdy, done, err} !== 5'b10000)
      $display("FAIL %s idle outputs pie/busy/rdy/done/err: got %b expected 10000", name,
               {out_pie, busy, in_rdy, done, err});
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_asserted");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_released");
  endtask

  task automatic test_default_sync();
    set_default_cfg(); c_pre = 1'b0;
    bits.delete(); bits.push_back(1); bits.push_back(0); bits.push_back(1); bits.push_back(0);
    launch();
    check_frame("default_sync", -1);
    @(negedge clk);
    check_idle("after_done");
  endtask

  task automatic test_default_preamble();
    set_default_cfg(); c_pre = 1'b1;
    rand_bits(3);
    launch();
    check_frame("default_preamble", -1);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      rand_cfg(); c_pre = 1'($urandom_range(0, 1));
      rand_bits($urandom_range(1, 6));
      @(negedge clk);
      launch();
      check_frame($sformatf("random_%0d", f), -1);
    end
  endtask

  task automatic test_underrun();
    rand_cfg(); c_pre = 1'b0;
    rand_bits(4);
    @(negedge clk);
    launch();
    check_frame("underrun", 1);
    @(negedge clk);
    check_idle("after_underrun");
  endtask

  task automatic bad_start(input string name);
    launch();
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({err, busy, out_pie, done} !== 4'b1010)
      $display("FAIL %s err/busy/pie/done: got %b expected 1010", name, {err, busy, out_pie, done});
    else n_pass++;
    @(negedge clk);
    check_idle({name, "_next"});
  endtask

  task automatic test_bad_config();
    set_default_cfg(); c_pw = 600; c_pre = 1'b0;
    bad_start("pw_ge_data0");
    rand_cfg(); c_d1 = c_d0; c_pre = 1'b0;
    bad_start("data0_eq_data1");
    rand_cfg(); c_trcal = c_d0 + c_d1; c_pre = 1'b1;
    bad_start("trcal_eq_rtcal");
    // The TRCAL bound only applies to preamble frames.
    c_pre = 1'b0; rand_bits(2);
    launch();
    check_frame("sync_ignores_trcal", -1);
  endtask

  task automatic test_reset_mid_rtcal();
    set_default_cfg(); c_pre = 1'b1;
    bits.delete(); bits.push_back(1);
    build_model();
    @(negedge clk);
    launch();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (out_pie !== exp_wave[1999]) $display("FAIL mid_rtcal pie before reset: got %b expected %b", out_pie, exp_wave[1999]);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_pie, busy} !== 2'b10) $display("FAIL async_reset pie/busy: got %b expected 10", {out_pie, busy});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_mid_reset");
    rand_cfg(); c_pre = 1'b0; rand_bits(2);
    launch();
    check_frame("frame_after_reset", -1);
  endtask

  task automatic test_back_to_back();
    rand_cfg(); c_pre = 1'b0; rand_bits(2);
    @(negedge clk);
    launch();
    check_frame("b2b_first", -1);
    set_default_cfg(); c_delim = 100; c_pre = 1'b0; rand_bits(2);
    launch();
    check_frame("b2b_second", -1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_preamble = 1'b0;
    in_dat = 1'b0; in_vld = 1'b0; in_last = 1'b0;
    cfg_pw = '0; cfg_data0 = '0; cfg_data1 = '0; cfg_delim = '0; cfg_trcal = '0;
    test_reset();
    test_default_sync();
    test_default_preamble();
    test_random_frames();
    test_underrun();
    test_bad_config();
    test_reset_mid_rtcal();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
